// File: rtl/crc_param_faulty_memory.sv
// -----------------------------------------------------------------------------
// crc_param_faulty_memory
//
// CRC-protected word memory with burst fault injection on the read path.
// Each entry holds a codeword {data, crc}. Codeword bit 0 is the crc LSB.
// The CRC is computed bit-serially, MSB of the data first. It uses init 0,
// no reflection and no final XOR. A write or read takes DATA_W+1 cycles after
// the accept edge. The design only detects errors; it does not correct them.
//
// Optional feature macro: CRC_MEM_ERR_LOG_EN. When it is defined, the module
// has the err_count and last_err_addr ports and the logic that drives them.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset (clears memory as well)
//   write, read         requests; sampled only while idle, write has priority
//   data_in, addr_in    write data / access address
//   fault_addr          lowest codeword bit of the injected burst
//   burst_error_length  burst length minus one
//   fault_enable        apply the burst mask to this read
//   mem_write_busy      write in progress
//   read_busy           read in progress
//   data_valid          data_out / error_detected valid (held until next op)
//   error_detected      CRC mismatch on the last read
//   data_out            data field of the last read (uncorrected)
//   err_count           [CRC_MEM_ERR_LOG_EN] saturating detected-error count
//   last_err_addr       [CRC_MEM_ERR_LOG_EN] address of the latest error
// -----------------------------------------------------------------------------
module crc_param_faulty_memory #(
    parameter int               DATA_W    = 8,
    parameter int               ADDR_W    = 4,
    parameter int               CRC_W     = 4,
    parameter logic [CRC_W-1:0] POLY      = 4'h3,
    parameter int               BURST_W   = 2,
    parameter int               FA_W      = 4,
    parameter int               ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [FA_W-1:0]      fault_addr,
    input  logic [BURST_W-1:0]   burst_error_length,
    input  logic                 fault_enable,
    output logic                 mem_write_busy,
    output logic                 read_busy,
    output logic                 data_valid,
    output logic                 error_detected,
    output logic [DATA_W-1:0]    data_out
`ifdef CRC_MEM_ERR_LOG_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    last_err_addr
`endif
);

    localparam int CW_W  = DATA_W + CRC_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WCALC  = 3'd1;
    localparam logic [2:0] ST_WSTORE = 3'd2;
    localparam logic [2:0] ST_RCALC  = 3'd3;
    localparam logic [2:0] ST_RCHECK = 3'd4;

    // One serial CRC step. The x^CRC_W term of the generator is implicit.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic             b);
        logic fb;
        fb       = crc[CRC_W-1] ^ b;
        crc_step = (crc << 1) ^ (fb ? POLY : {CRC_W{1'b0}});
    endfunction

    logic [2:0]        state_r;
    logic [CW_W-1:0]   mem_r [DEPTH];
    logic [CW_W-1:0]   cw_r;      // write: {data, 0}; read: faulted codeword
    logic [CRC_W-1:0]  crc_r;
    logic [CNT_W-1:0]  cnt_r;     // data bit being folded in, counts down
    logic [ADDR_W-1:0] addr_r;
    logic              wbusy_r;
    logic              rbusy_r;
    logic              valid_r;
    logic              err_r;
    logic [DATA_W-1:0] dout_r;
    logic [CW_W-1:0]   mask_s;
    logic [DATA_W-1:0] data_field_s;

    assign data_field_s   = cw_r[CW_W-1:CRC_W];
    assign mem_write_busy = wbusy_r;
    assign read_busy      = rbusy_r;
    assign data_valid     = valid_r;
    assign error_detected = err_r;
    assign data_out       = dout_r;

    // Burst mask over codeword bits. Bits past the top of the codeword are dropped (no wrap).
    always_comb begin
        mask_s = {CW_W{1'b0}};
        for (int i = 0; i < CW_W; i++) begin
            mask_s[i] = fault_enable &&
                        (i >= int'(fault_addr)) &&
                        (i <= int'(fault_addr) + int'(burst_error_length));
        end
    end

    // Codeword storage: cleared on reset, written only in WSTORE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {CW_W{1'b0}};
            end
        end else if (state_r == ST_WSTORE) begin
            mem_r[addr_r] <= {data_field_s, crc_r};
        end else begin
        end
    end

    // Sequencer and datapath. A reset in mid-operation aborts it without a store or data_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cw_r    <= {CW_W{1'b0}};
            crc_r   <= {CRC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            wbusy_r <= 1'b0;
            rbusy_r <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            dout_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (write) begin
                        addr_r  <= addr_in;
                        cw_r    <= {data_in, {CRC_W{1'b0}}};
                        crc_r   <= {CRC_W{1'b0}};
                        cnt_r   <= CNT_W'(DATA_W - 1);
                        wbusy_r <= 1'b1;
                        valid_r <= 1'b0;
                        state_r <= ST_WCALC;
                    end else if (read) begin
                        // Fault only corrupts the copy being checked, never the array.
                        addr_r  <= addr_in;
                        cw_r    <= mem_r[addr_in] ^ mask_s;
                        crc_r   <= {CRC_W{1'b0}};
                        cnt_r   <= CNT_W'(DATA_W - 1);
                        rbusy_r <= 1'b1;
                        valid_r <= 1'b0;
                        state_r <= ST_RCALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WCALC: begin
                    crc_r <= crc_step(crc_r, data_field_s[cnt_r]);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_WSTORE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_WSTORE: begin
                    wbusy_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_RCALC: begin
                    crc_r <= crc_step(crc_r, data_field_s[cnt_r]);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_RCHECK;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RCHECK: begin
                    rbusy_r <= 1'b0;
                    valid_r <= 1'b1;
                    dout_r  <= data_field_s;
                    err_r   <= (crc_r != cw_r[CRC_W-1:0]);
                    state_r <= ST_IDLE;
                end
                default: begin
                    wbusy_r <= 1'b0;
                    rbusy_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CRC_MEM_ERR_LOG_EN
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic [ADDR_W-1:0]    last_addr_r;

    assign err_count     = err_cnt_r;
    assign last_err_addr = last_addr_r;

    // Error log: saturating mismatch count and the address of the latest mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r   <= {ERR_CNT_W{1'b0}};
            last_addr_r <= {ADDR_W{1'b0}};
        end else if ((state_r == ST_RCHECK) && (crc_r != cw_r[CRC_W-1:0])) begin
            last_addr_r <= addr_r;
            if (err_cnt_r != {ERR_CNT_W{1'b1}}) begin
                err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end else begin
        end
    end
`endif

endmodule

// File: tb/tb_crc_param_faulty_memory.sv
// -----------------------------------------------------------------------------
// Testbench for crc_param_faulty_memory using the default parameters.
// The reference model keeps a plain data array. It computes the CRC as the
// remainder of data * x^4 modulo x^4+x+1 by polynomial long division.
// -----------------------------------------------------------------------------
module tb_crc_param_faulty_memory;

    localparam int DW = 8;
    localparam int CW = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [3:0] addr_in = 4'h0;
    logic [3:0] fault_addr = 4'h0;
    logic [1:0] burst_error_length = 2'b00;
    logic       fault_enable = 1'b0;
    logic       mem_write_busy;
    logic       read_busy;
    logic       data_valid;
    logic       error_detected;
    logic [7:0] data_out;
`ifdef CRC_MEM_ERR_LOG_EN
    logic [7:0] err_count;
    logic [3:0] last_err_addr;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem_m [16];
    int         exp_err_cnt = 0;
    logic [3:0] exp_last_addr = 4'h0;

    crc_param_faulty_memory dut (
        .clk                (clk),
        .rst                (rst),
        .write              (write),
        .read               (read),
        .data_in            (data_in),
        .addr_in            (addr_in),
        .fault_addr         (fault_addr),
        .burst_error_length (burst_error_length),
        .fault_enable       (fault_enable),
        .mem_write_busy     (mem_write_busy),
        .read_busy          (read_busy),
        .data_valid         (data_valid),
        .error_detected     (error_detected),
        .data_out           (data_out)
`ifdef CRC_MEM_ERR_LOG_EN
        ,
        .err_count          (err_count),
        .last_err_addr      (last_err_addr)
`endif
    );

    always #5 clk = ~clk;

    // CRC as the remainder of data * x^4 divided by the generator 1_0011.
    function automatic logic [3:0] ref_crc(input logic [7:0] d);
        logic [11:0] r;
        r = {d, 4'b0000};
        for (int i = 11; i >= 4; i--) begin
            if (r[i]) r = r ^ (12'h013 << (i - 4));
        end
        return r[3:0];
    endfunction

    function automatic logic [11:0] ref_mask(input logic en, input int fa, input int len);
        logic [11:0] m;
        m = 12'h000;
        for (int i = 0; i < CW; i++) m[i] = en && (i >= fa) && (i <= fa + len);
        return m;
    endfunction

    task automatic model_note_read(input logic [3:0] a, input logic err);
        if (err) begin
            if (exp_err_cnt < 255) exp_err_cnt++;
            exp_last_addr = a;
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, output int cyc);
        @(negedge clk);
        write = 1'b1; addr_in = a; data_in = d;
        @(negedge clk);
        write = 1'b0;
        cyc = 0;
        while (mem_write_busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic en, input logic [3:0] fa,
                           input logic [1:0] len, output int cyc, output logic early_dv,
                           output logic dv, output logic [7:0] dout, output logic err);
        @(negedge clk);
        read = 1'b1; addr_in = a; fault_enable = en; fault_addr = fa; burst_error_length = len;
        @(negedge clk);
        read = 1'b0; fault_enable = 1'b0;
        early_dv = data_valid;
        cyc = 0;
        while (read_busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        dv = data_valid; dout = data_out; err = error_detected;
    endtask

    task automatic test_reset();
        int cyc; logic edv, dv, err; logic [7:0] d;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({mem_write_busy, read_busy, data_valid, error_detected, data_out} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {mem_write_busy, read_busy, data_valid, error_detected, data_out});
        end
`ifdef CRC_MEM_ERR_LOG_EN
        tests_run++;
        if (err_count !== 8'h00 || last_err_addr !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_errlog: got cnt=%0d addr=%0d, expected 0/0", err_count, last_err_addr);
        end
`endif
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        exp_err_cnt = 0; exp_last_addr = 4'h0;
        do_read(4'd9, 1'b0, 4'd0, 2'd0, cyc, edv, dv, d, err);
        tests_run++;
        if (dv !== 1'b1 || d !== 8'h00 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_clear: got dv=%b d=%h err=%b, expected 1/00/0", dv, d, err);
        end
    endtask

    task automatic test_write_read();
        int cyc; logic edv, dv, err; logic [7:0] d;
        do_write(4'd0, 8'hA5, cyc);
        mem_m[0] = 8'hA5;
        tests_run++;
        if (cyc !== DW + 1) begin
            tests_failed++;
            $display("FAIL write_busy_len: got %0d, expected %0d", cyc, DW + 1);
        end
        tests_run++;
        if (dut.mem_r[0] !== {8'hA5, 4'hB}) begin
            tests_failed++;
            $display("FAIL stored_cw: got %h, expected a5b", dut.mem_r[0]);
        end
        do_read(4'd0, 1'b0, 4'd0, 2'd0, cyc, edv, dv, d, err);
        tests_run++;
        if (cyc !== DW + 1 || edv !== 1'b0 || dv !== 1'b1 || d !== 8'hA5 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_a5: got cyc=%0d early_dv=%b dv=%b d=%h err=%b, expected 9/0/1/a5/0",
                     cyc, edv, dv, d, err);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
            tests_failed++;
            $display("FAIL hold_valid: got dv=%b d=%h, expected 1/a5", data_valid, data_out);
        end
    endtask

    task automatic test_fault_patterns();
        int cyc; logic edv, dv, err; logic [7:0] d;
        do_write(4'd2, 8'h7E, cyc);
        mem_m[2] = 8'h7E;
        do_read(4'd2, 1'b1, 4'd4, 2'd3, cyc, edv, dv, d, err);
        model_note_read(4'd2, 1'b1);
        tests_run++;
        if (dv !== 1'b1 || d !== 8'h71 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst4_data: got dv=%b d=%h err=%b, expected 1/71/1", dv, d, err);
        end
        do_read(4'd0, 1'b1, 4'd0, 2'd0, cyc, edv, dv, d, err);
        model_note_read(4'd0, 1'b1);
        tests_run++;
        if (d !== 8'hA5 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL crc_lsb_flip: got d=%h err=%b, expected a5/1", d, err);
        end
        do_read(4'd0, 1'b1, 4'd10, 2'd3, cyc, edv, dv, d, err);
        model_note_read(4'd0, 1'b1);
        tests_run++;
        if (d !== 8'h65 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL clipped_burst: got d=%h err=%b, expected 65/1", d, err);
        end
        do_read(4'd2, 1'b0, 4'd4, 2'd3, cyc, edv, dv, d, err);
        tests_run++;
        if (d !== 8'h7E || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_not_stored: got d=%h err=%b, expected 7e/0", d, err);
        end
`ifdef CRC_MEM_ERR_LOG_EN
        tests_run++;
        if (err_count !== 8'(exp_err_cnt) || last_err_addr !== exp_last_addr) begin
            tests_failed++;
            $display("FAIL errlog_faults: got cnt=%0d addr=%0d, expected %0d/%0d",
                     err_count, last_err_addr, exp_err_cnt, exp_last_addr);
        end
`endif
    endtask

    task automatic test_write_priority();
        int cyc; logic edv, dv, err; logic [7:0] d; logic saw_read_busy;
        @(negedge clk);
        write = 1'b1; read = 1'b1; addr_in = 4'd1; data_in = 8'h3C;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        tests_run++;
        if (mem_write_busy !== 1'b1 || read_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_wins: got wbusy=%b rbusy=%b, expected 1/0", mem_write_busy, read_busy);
        end
        saw_read_busy = 1'b0;
        cyc = 0;
        while (mem_write_busy && cyc < 50) begin
            @(negedge clk);
            saw_read_busy |= read_busy;
            cyc++;
        end
        mem_m[1] = 8'h3C;
        tests_run++;
        if (saw_read_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_dropped: got read_busy=%b, expected 0", saw_read_busy);
        end
        do_read(4'd1, 1'b0, 4'd0, 2'd0, cyc, edv, dv, d, err);
        tests_run++;
        if (d !== 8'h3C || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL priority_read: got d=%h err=%b, expected 3c/0", d, err);
        end
    endtask

    task automatic test_busy_ignored();
        int cyc; logic saw_wbusy;
        @(negedge clk);
        read = 1'b1; addr_in = 4'd1;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        write = 1'b1; read = 1'b1; addr_in = 4'd1; data_in = 8'hFF;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        saw_wbusy = mem_write_busy;
        cyc = 0;
        while (read_busy && cyc < 50) begin
            @(negedge clk);
            saw_wbusy |= mem_write_busy;
            cyc++;
        end
        tests_run++;
        if (saw_wbusy !== 1'b0 || data_out !== 8'h3C || data_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_ignored: got wbusy_seen=%b d=%h dv=%b, expected 0/3c/1",
                     saw_wbusy, data_out, data_valid);
        end
        tests_run++;
        if (dut.mem_r[1][11:4] !== 8'h3C) begin
            tests_failed++;
            $display("FAIL busy_no_store: got %h, expected 3c", dut.mem_r[1][11:4]);
        end
    endtask

    task automatic test_random();
        int cyc; logic edv, dv, err; logic [7:0] d;
        logic [3:0] a; logic [7:0] wd; logic en; logic [3:0] fa; logic [1:0] len;
        logic [11:0] cw; logic exp_err;
        for (int n = 0; n < 30; n++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                wd = 8'($urandom);
                do_write(a, wd, cyc);
                mem_m[a] = wd;
                tests_run++;
                if (cyc !== DW + 1) begin
                    tests_failed++;
                    $display("FAIL rand_write_len: got %0d, expected %0d", cyc, DW + 1);
                end
            end else begin
                en  = 1'($urandom_range(0, 1));
                fa  = 4'($urandom_range(0, 15));
                len = 2'($urandom_range(0, 3));
                cw  = {mem_m[a], ref_crc(mem_m[a])} ^ ref_mask(en, int'(fa), int'(len));
                exp_err = (ref_crc(cw[11:4]) != cw[3:0]);
                do_read(a, en, fa, len, cyc, edv, dv, d, err);
                model_note_read(a, exp_err);
                tests_run++;
                if (cyc !== DW + 1 || dv !== 1'b1 || d !== cw[11:4] || err !== exp_err) begin
                    tests_failed++;
                    $display("FAIL rand_read a=%0d en=%b fa=%0d len=%0d: got cyc=%0d dv=%b d=%h err=%b, expected 9/1/%h/%b",
                             a, en, fa, len, cyc, dv, d, err, cw[11:4], exp_err);
                end
`ifdef CRC_MEM_ERR_LOG_EN
                tests_run++;
                if (err_count !== 8'(exp_err_cnt) || last_err_addr !== exp_last_addr) begin
                    tests_failed++;
                    $display("FAIL rand_errlog: got cnt=%0d addr=%0d, expected %0d/%0d",
                             err_count, last_err_addr, exp_err_cnt, exp_last_addr);
                end
`endif
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc; logic edv, dv, err; logic [7:0] d;
        @(negedge clk);
        write = 1'b1; addr_in = 4'd3; data_in = 8'h55;
        @(negedge clk);
        write = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (mem_write_busy !== 1'b0 || data_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort: got wbusy=%b dv=%b, expected 0/0", mem_write_busy, data_valid);
        end
`ifdef CRC_MEM_ERR_LOG_EN
        tests_run++;
        if (err_count !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_errcnt: got %0d, expected 0", err_count);
        end
`endif
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        exp_err_cnt = 0; exp_last_addr = 4'h0;
        do_read(4'd3, 1'b0, 4'd0, 2'd0, cyc, edv, dv, d, err);
        tests_run++;
        if (dv !== 1'b1 || d !== 8'h00 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_read3: got dv=%b d=%h err=%b, expected 1/00/0", dv, d, err);
        end
        do_read(4'd0, 1'b1, 4'd2, 2'd1, cyc, edv, dv, d, err);
        tests_run++;
        if (d !== 8'h00 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_fault: got d=%h err=%b, expected 00/1", d, err);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fault_patterns();
        test_write_priority();
        test_busy_ignored();
        test_random();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
